// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA of up to STEP bits per cycle with valid/ready handshakes.
// Define SEQ_SHIFTER_ROTATE_EN to make mode 2'b10 a rotate-left; otherwise it aliases SLL.
module seq_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WIDTH-1:0]         value_i,
    input  logic [$clog2(WIDTH)-1:0] shamt_i,
    input  logic [1:0]               mode_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         value_o,
    output logic                     busy_o
);

    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;

    logic [SW:0]      step_w;
    logic [SW:0]      rem_ext;
    logic [SW:0]      k;
    logic [WIDTH-1:0] shifted;

    assign step_w  = STEP[SW:0];
    assign rem_ext = {1'b0, rem_q};
    assign k       = (rem_ext < step_w) ? rem_ext : step_w;

`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [SW:0] width_w;
    assign width_w = WIDTH[SW:0];
`endif

    always_comb begin
        shifted = data_q << k;
        case (mode_q)
            2'b01:   shifted = data_q >> k;
            // Working register MSB never changes under SRA, so it is the operand's sign.
            2'b11:   shifted = WIDTH'($signed(data_q) >>> k);
`ifdef SEQ_SHIFTER_ROTATE_EN
            2'b10:   shifted = (data_q << k) | (data_q >> (width_w - k));
`else
            2'b10:   shifted = data_q << k;
`endif
            default: shifted = data_q << k;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    data_d  = value_i;
                    mode_d  = mode_i;
                    rem_d   = shamt_i;
                    state_d = (shamt_i == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                data_d = shifted;
                rem_d  = rem_q - k[SW-1:0];
                if (rem_ext == k) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign value_o     = data_q;

endmodule
